// File: rtl/crypto_job_scheduler.sv
// Round-robin scheduler sharing one SPI crypto master link between two job requesters.
// Sequences master load, MOSI shift timing, done-strobe wait with timeout, MISO capture and response.
module crypto_job_scheduler #(
  parameter int NK      = 8,
  parameter int NB      = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [1:0]       mode_i,
  input  logic [32*NB-1:0] msg0_i,
  input  logic [32*NK-1:0] key0_i,
  input  logic [32*NB-1:0] msg1_i,
  input  logic [32*NK-1:0] key1_i,
  output logic [1:0]       ack_o,
  output logic             err_o,
  output logic [32*NB-1:0] result_o,
  output logic             busy_o,
  output logic             m_load_o,
  output logic             m_mode_o,
  output logic [32*NB-1:0] m_msg_o,
  output logic [32*NK-1:0] m_key_o,
  input  logic             done_enc_i,
  input  logic             done_dec_i,
  input  logic [32*NB-1:0] m_rx_data_i
);
  localparam int MSG_W = 32 * NB;
  localparam int KEY_W = 32 * NK;
  localparam logic [31:0] TX_LAST   = 32'(MSG_W + KEY_W - 1);
  localparam logic [31:0] RX_LAST   = 32'(MSG_W - 1);
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT_TX, WAIT_DONE, SHIFT_RX, RESP, ABORT
  } state_t;

  state_t      state, state_next;
  logic [31:0] cnt, cnt_next;
  logic        grant;
  logic        win;
  logic        sel_done;
  logic        prev_done;
  logic        done_fall;

  // The requester that did not win last time takes a tie.
  assign win       = (req_i == 2'b11) ? ~grant : req_i[1];
  assign sel_done  = m_mode_o ? done_dec_i : done_enc_i;
  assign done_fall = prev_done & ~sel_done;
  assign busy_o    = (state != IDLE);
  assign m_load_o  = (state == LOAD);

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: if (|req_i) state_next = LOAD;
      LOAD: begin
        cnt_next   = TX_LAST;
        state_next = SHIFT_TX;
      end
      SHIFT_TX: begin
        if (cnt == '0) begin
          state_next = WAIT_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 32'd1;
        end
      end
      WAIT_DONE: begin
        if (done_fall) begin
          state_next = SHIFT_RX;
          cnt_next   = RX_LAST;
        end else if (cnt == WAIT_LAST) begin
          state_next = ABORT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      SHIFT_RX: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 32'd1;
      end
      RESP:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response registers load on entry to RESP/ABORT so ack_o is high exactly while in those states.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      grant     <= 1'b1;
      prev_done <= 1'b0;
      ack_o     <= '0;
      err_o     <= 1'b0;
      result_o  <= '0;
      m_mode_o  <= 1'b0;
      m_msg_o   <= '0;
      m_key_o   <= '0;
    end else begin
      prev_done <= sel_done;
      ack_o     <= '0;
      if (state == IDLE && |req_i) begin
        grant    <= win;
        m_mode_o <= mode_i[win];
        m_msg_o  <= win ? msg1_i : msg0_i;
        m_key_o  <= win ? key1_i : key0_i;
      end
      if (state_next == RESP) begin
        ack_o[grant] <= 1'b1;
        err_o        <= 1'b0;
        result_o     <= m_rx_data_i;
      end
      if (state_next == ABORT) begin
        ack_o[grant] <= 1'b1;
        err_o        <= 1'b1;
      end
    end
  end
endmodule
